// File: rtl/pe_pkg.sv
// pe_pkg: shared constants, saturating adder and parameter legality check for the PE family
// Contents:
//   MODE_WS / MODE_OS : partial-sum mode encodings
//   MAX_W             : widest accumulator sat_add can serve (ACC_W must stay below it)
//   sat_add           : signed add at width w, with optional clamping and an overflow flag
//   params_ok         : elaboration-time parameter legality
package pe_pkg;
    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;
    localparam int   MAX_W   = 128;

    typedef struct packed {
        logic [MAX_W-1:0] sum;
        logic             ovf;
    } add_res_t;

    // Operands arrive sign-extended to MAX_W. The exact sum then fits in w+1 bits,
    // so bit w is the true sign and bit w-1 the sign at width w: they differ on overflow.
    function automatic add_res_t sat_add(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                         input logic [6:0] w, input logic sat);
        logic [MAX_W-1:0] s;
        logic [MAX_W-1:0] lim;
        add_res_t         r;
        s     = a + b;
        lim   = (MAX_W'(1) << (w - 7'd1)) - MAX_W'(1);
        r.ovf = s[w] ^ s[w - 7'd1];
        r.sum = (r.ovf && sat) ? (s[w] ? ~lim : lim) : s;
        return r;
    endfunction

    function automatic logic params_ok(input int data_w, input int acc_w, input int mul_lat);
        return data_w >= 1 && acc_w >= 2 * data_w && acc_w < MAX_W && mul_lat >= 1;
    endfunction
endpackage

// File: rtl/pe_mul_pipe.sv
// pe_mul_pipe: MUL_LAT-stage signed multiplier with a travelling valid bit and sync clear
// Ports:
//   clk_i, rst_i (async, active-high), clr_i (sync clear of all stages)
//   a_i, b_i  : signed DATA_W operands, captured by stage 1 every edge
//   vld_i     : valid accompanying the operands
//   prod_o    : signed 2*DATA_W product from the last stage, vld_o its valid
//   busy_o    : any stage holds a valid product
module pe_mul_pipe
    import pe_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int MUL_LAT = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic signed [DATA_W-1:0]   a_i,
    input  logic signed [DATA_W-1:0]   b_i,
    input  logic                       vld_i,
    output logic signed [2*DATA_W-1:0] prod_o,
    output logic                       vld_o,
    output logic                       busy_o
);
    logic signed [2*DATA_W-1:0] prod_q [MUL_LAT];
    logic [MUL_LAT-1:0]         vld_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clr_i) begin
            vld_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
        end else begin
            // the concatenation is one bit too wide; truncation drops the oldest valid
            vld_q     <= MUL_LAT'({vld_q, vld_i});
            prod_q[0] <= a_i * b_i;
            for (int i = 1; i < MUL_LAT; i++) prod_q[i] <= prod_q[i-1];
        end
    end

    assign prod_o = prod_q[MUL_LAT-1];
    assign vld_o  = vld_q[MUL_LAT-1];
    assign busy_o = |vld_q;
endmodule

// File: rtl/pe_mac_param.sv
// pe_mac_param: systolic PE with double-buffered stationary B, pipelined MAC, WS chaining or OS accumulate/drain
// Ports:
//   clk_i, rst_i (async, active-high), data_clear_i (sync clear, B registers hold)
//   mode_i       : MODE_WS chains ps downward, MODE_OS accumulates locally
//   b_load_i/b_swap_i/b_i, b_o : shadow load, shadow->active swap, shadow forwarded down
//   a_valid_i/a_i, a_valid_o/a_o : A from left, registered to right
//   ps_valid_i/ps_i, drain_i, ps_valid_o/ps_o : partial-sum chain and OS drain
//   ovf_o        : sticky overflow, busy_o : A register or multiplier holds a token
module pe_mac_param
    import pe_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 32,
    parameter int MUL_LAT = 5,
    parameter int SAT_EN  = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     data_clear_i,
    input  logic                     mode_i,
    input  logic                     b_load_i,
    input  logic                     b_swap_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [DATA_W-1:0] b_o,
    input  logic                     a_valid_i,
    input  logic signed [DATA_W-1:0] a_i,
    output logic                     a_valid_o,
    output logic signed [DATA_W-1:0] a_o,
    input  logic                     ps_valid_i,
    input  logic signed [ACC_W-1:0]  ps_i,
    input  logic                     drain_i,
    output logic                     ps_valid_o,
    output logic signed [ACC_W-1:0]  ps_o,
    output logic                     ovf_o,
    output logic                     busy_o
);
    if (!params_ok(DATA_W, ACC_W, MUL_LAT)) begin : g_bad_params
        $error("pe_mac_param: illegal DATA_W/ACC_W/MUL_LAT");
    end

    logic signed [DATA_W-1:0]   b_sh_q, b_act_q, a_q;
    logic                       a_vld_q, ps_vld_q, ps_vld_d, ovf_q, ovf_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d, ps_q, ps_d, add_b;
    logic signed [2*DATA_W-1:0] prod;
    logic                       prod_vld, pipe_busy, unused_hi;
    add_res_t                   r;

    pe_mul_pipe #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) u_mul (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (data_clear_i),
        .a_i    (a_q),
        .b_i    (b_act_q),
        .vld_i  (a_vld_q),
        .prod_o (prod),
        .vld_o  (prod_vld),
        .busy_o (pipe_busy)
    );

    assign add_b = prod_vld ? ACC_W'(prod) : '0;

    // One adder serves both modes: WS adds to ps_i, OS adds to the accumulator.
    // In OS a drain routes the same sum to ps, so a coincident product is counted once.
    always_comb begin
        r        = sat_add(MAX_W'(mode_i == MODE_OS ? acc_q : ps_i), MAX_W'(add_b), 7'(ACC_W), SAT_EN != 0);
        acc_d    = acc_q;
        ps_d     = ps_q;
        ps_vld_d = 1'b0;
        ovf_d    = ovf_q;
        if (mode_i == MODE_OS) begin
            acc_d    = drain_i ? '0 : r.sum[ACC_W-1:0];
            ps_vld_d = drain_i | ps_valid_i;
            ps_d     = drain_i ? r.sum[ACC_W-1:0] : (ps_valid_i ? ps_i : ps_q);
            ovf_d    = ovf_q | r.ovf;
        end else begin
            ps_vld_d = ps_valid_i;
            ps_d     = ps_valid_i ? r.sum[ACC_W-1:0] : ps_q;
            ovf_d    = ovf_q | (r.ovf & ps_valid_i);
        end
    end

    assign unused_hi = ^r.sum[MAX_W-1:ACC_W];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_sh_q   <= '0;
            b_act_q  <= '0;
            a_q      <= '0;
            a_vld_q  <= 1'b0;
            acc_q    <= '0;
            ps_q     <= '0;
            ps_vld_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (data_clear_i) begin
            a_q      <= '0;
            a_vld_q  <= 1'b0;
            acc_q    <= '0;
            ps_q     <= '0;
            ps_vld_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (b_load_i) b_sh_q <= b_i;
            if (b_swap_i) b_act_q <= b_sh_q;
            a_vld_q <= a_valid_i;
            if (a_valid_i) a_q <= a_i;
            acc_q    <= acc_d;
            ps_q     <= ps_d;
            ps_vld_q <= ps_vld_d;
            ovf_q    <= ovf_d;
        end
    end

    assign b_o        = b_sh_q;
    assign a_o        = a_q;
    assign a_valid_o  = a_vld_q;
    assign ps_o       = ps_q;
    assign ps_valid_o = ps_vld_q;
    assign ovf_o      = ovf_q;
    assign busy_o     = a_vld_q | pipe_busy;
endmodule

// File: tb/tb_pe_mac_param.sv
// tb_pe_mac_param: directed self-checking bench for pe_mac_param (saturating and wrapping instances)
module tb_pe_mac_param;
    logic               clk = 1'b0;
    logic               rst, data_clear, mode, b_load, b_swap, a_valid, ps_valid, drain;
    logic signed [15:0] b_in, a_in;
    logic signed [31:0] ps_in;

    logic signed [15:0] b_o, a_o, w_b_o, w_a_o;
    logic               a_valid_o, ps_valid_o, ovf_o, busy_o;
    logic               w_a_valid_o, w_ps_valid_o, w_ovf_o, w_busy_o;
    logic signed [31:0] ps_o, w_ps_o;

    int pass = 0;
    int total = 0;

    always #5 clk = ~clk;

    pe_mac_param #(.DATA_W(16), .ACC_W(32), .MUL_LAT(5), .SAT_EN(1)) dut (
        .clk_i(clk), .rst_i(rst), .data_clear_i(data_clear), .mode_i(mode),
        .b_load_i(b_load), .b_swap_i(b_swap), .b_i(b_in), .b_o(b_o),
        .a_valid_i(a_valid), .a_i(a_in), .a_valid_o(a_valid_o), .a_o(a_o),
        .ps_valid_i(ps_valid), .ps_i(ps_in), .drain_i(drain),
        .ps_valid_o(ps_valid_o), .ps_o(ps_o), .ovf_o(ovf_o), .busy_o(busy_o)
    );

    pe_mac_param #(.DATA_W(16), .ACC_W(32), .MUL_LAT(5), .SAT_EN(0)) dut_w (
        .clk_i(clk), .rst_i(rst), .data_clear_i(data_clear), .mode_i(mode),
        .b_load_i(b_load), .b_swap_i(b_swap), .b_i(b_in), .b_o(w_b_o),
        .a_valid_i(a_valid), .a_i(a_in), .a_valid_o(w_a_valid_o), .a_o(w_a_o),
        .ps_valid_i(ps_valid), .ps_i(ps_in), .drain_i(drain),
        .ps_valid_o(w_ps_valid_o), .ps_o(w_ps_o), .ovf_o(w_ovf_o), .busy_o(w_busy_o)
    );

    logic mode_prev = 1'b0;
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(drain && ps_valid)) else $error("drain and ps_valid_in asserted together");
            assert (!(mode != mode_prev && busy_o)) else $error("mode changed while busy");
        end
        mode_prev <= mode;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_b(input logic signed [15:0] v);
        b_load = 1'b1; b_in = v; tick(1);
        b_load = 1'b0; b_swap = 1'b1; tick(1);
        b_swap = 1'b0;
    endtask

    task automatic feed(input logic signed [15:0] v);
        a_valid = 1'b1; a_in = v; tick(1);
        a_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic seen;
        load_b(16'sd9);
        a_valid = 1'b1; a_in = 16'sd5; tick(2);
        total++; if (a_o !== 16'sd5 || b_o !== 16'sd9) $display("FAIL rst_pre: a_o=%0d b_o=%0d want 5 9", a_o, b_o); else pass++;
        #2 rst = 1'b1;
        #1;
        total++; if ({a_o, b_o, ps_o, a_valid_o, ps_valid_o, ovf_o, busy_o} !== '0)
            $display("FAIL rst_async: a=%0d b=%0d ps=%0d av=%b pv=%b ovf=%b busy=%b want all 0", a_o, b_o, ps_o, a_valid_o, ps_valid_o, ovf_o, busy_o);
        else pass++;
        a_valid = 1'b0;
        tick(1);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            seen |= ps_valid_o | busy_o;
        end
        total++; if (seen !== 1'b0) $display("FAIL rst_release: ps_valid_o/busy seen=%b want 0", seen); else pass++;
    endtask

    task automatic test_ws;
        mode = 1'b0;
        load_b(16'sd3);
        feed(16'sd7);
        total++; if (a_o !== 16'sd7 || a_valid_o !== 1'b1) $display("FAIL ws_a_fwd: a_o=%0d av=%b want 7 1", a_o, a_valid_o); else pass++;
        tick(5);
        ps_valid = 1'b1; ps_in = 32'sd100; tick(1);
        ps_valid = 1'b0;
        total++; if (ps_o !== 32'sd121 || ps_valid_o !== 1'b1) $display("FAIL ws_sum: ps_o=%0d pv=%b want 121 1", ps_o, ps_valid_o); else pass++;
        tick(1);
        total++; if (ps_valid_o !== 1'b0 || ps_o !== 32'sd121) $display("FAIL ws_hold: ps_o=%0d pv=%b want 121 0", ps_o, ps_valid_o); else pass++;
        ps_valid = 1'b1; ps_in = -32'sd50; tick(1);
        ps_valid = 1'b0;
        total++; if (ps_o !== -32'sd50 || ps_valid_o !== 1'b1) $display("FAIL ws_noprod: ps_o=%0d pv=%b want -50 1", ps_o, ps_valid_o); else pass++;
        tick(2);
    endtask

    task automatic test_os;
        mode = 1'b1;
        load_b(16'sd5);
        feed(16'sd2); feed(16'sd4); feed(-16'sd3);
        tick(6);
        drain = 1'b1; tick(1);
        drain = 1'b0;
        total++; if (ps_o !== 32'sd15 || ps_valid_o !== 1'b1) $display("FAIL os_drain: ps_o=%0d pv=%b want 15 1", ps_o, ps_valid_o); else pass++;
        tick(1);
        total++; if (ps_valid_o !== 1'b0) $display("FAIL os_pulse: pv=%b want 0", ps_valid_o); else pass++;
        drain = 1'b1; tick(1);
        drain = 1'b0;
        total++; if (ps_o !== 32'sd0 || ps_valid_o !== 1'b1) $display("FAIL os_acc_zero: ps_o=%0d pv=%b want 0 1", ps_o, ps_valid_o); else pass++;
        feed(16'sd2); feed(16'sd4); feed(-16'sd3);
        tick(5);
        drain = 1'b1; tick(1);
        drain = 1'b0;
        total++; if (ps_o !== 32'sd15 || ps_valid_o !== 1'b1) $display("FAIL os_drain_coincident: ps_o=%0d pv=%b want 15 1", ps_o, ps_valid_o); else pass++;
        tick(2);
        drain = 1'b1; tick(1);
        drain = 1'b0;
        total++; if (ps_o !== 32'sd0) $display("FAIL os_no_double: ps_o=%0d want 0", ps_o); else pass++;
        ps_valid = 1'b1; ps_in = 32'sd77; tick(1);
        ps_valid = 1'b0;
        total++; if (ps_o !== 32'sd77 || ps_valid_o !== 1'b1) $display("FAIL os_passthru: ps_o=%0d pv=%b want 77 1", ps_o, ps_valid_o); else pass++;
        tick(2);
    endtask

    task automatic test_sat;
        mode = 1'b0;
        load_b(16'sh7FFF);
        feed(16'sh7FFF);
        tick(5);
        ps_valid = 1'b1; ps_in = 32'sh7FFFFFF0; tick(1);
        ps_valid = 1'b0;
        total++; if (ps_o !== 32'sh7FFFFFFF || ovf_o !== 1'b1) $display("FAIL sat_pos: ps_o=%h ovf=%b want 7fffffff 1", ps_o, ovf_o); else pass++;
        total++; if (w_ps_o !== 32'shBFFEFFF1 || w_ovf_o !== 1'b1) $display("FAIL wrap_pos: ps_o=%h ovf=%b want bffefff1 1", w_ps_o, w_ovf_o); else pass++;
        feed(-16'sd32768);
        tick(5);
        ps_valid = 1'b1; ps_in = 32'sh80000010; tick(1);
        ps_valid = 1'b0;
        total++; if (ps_o !== 32'sh80000000) $display("FAIL sat_neg: ps_o=%h want 80000000", ps_o); else pass++;
        total++; if (w_ps_o !== 32'sh40008010) $display("FAIL wrap_neg: ps_o=%h want 40008010", w_ps_o); else pass++;
        ps_valid = 1'b1; ps_in = 32'sd1; tick(1);
        ps_valid = 1'b0;
        total++; if (ps_o !== 32'sd1 || ovf_o !== 1'b1 || w_ovf_o !== 1'b1) $display("FAIL ovf_sticky: ps_o=%0d ovf=%b wovf=%b want 1 1 1", ps_o, ovf_o, w_ovf_o); else pass++;
        data_clear = 1'b1; tick(1);
        data_clear = 1'b0;
        total++; if (ovf_o !== 1'b0 || w_ovf_o !== 1'b0) $display("FAIL ovf_clear: ovf=%b wovf=%b want 0 0", ovf_o, w_ovf_o); else pass++;
    endtask

    task automatic test_bswap;
        load_b(16'sd2);
        b_load = 1'b1; b_in = 16'sd9; tick(1);
        b_load = 1'b0;
        total++; if (b_o !== 16'sd9) $display("FAIL b_out_shadow: b_o=%0d want 9", b_o); else pass++;
        a_valid = 1'b1; a_in = 16'sd10; tick(1);
        a_valid = 1'b0; b_swap = 1'b1; tick(1);
        b_swap = 1'b0; a_valid = 1'b1; a_in = 16'sd10; tick(1);
        a_valid = 1'b0;
        tick(3);
        ps_valid = 1'b1; ps_in = 32'sd0; tick(1);
        ps_valid = 1'b0;
        total++; if (ps_o !== 32'sd20) $display("FAIL bswap_old: ps_o=%0d want 20", ps_o); else pass++;
        tick(1);
        ps_valid = 1'b1; tick(1);
        ps_valid = 1'b0;
        total++; if (ps_o !== 32'sd90) $display("FAIL bswap_new: ps_o=%0d want 90", ps_o); else pass++;
        tick(2);
    endtask

    task automatic test_clear;
        logic seen;
        mode = 1'b1;
        load_b(16'sd8);
        feed(16'sd5);
        tick(6);
        feed(16'sd3);
        tick(3);
        data_clear = 1'b1; tick(1);
        data_clear = 1'b0;
        total++; if (busy_o !== 1'b0 || ps_valid_o !== 1'b0) $display("FAIL clr_busy: busy=%b pv=%b want 0 0", busy_o, ps_valid_o); else pass++;
        total++; if (b_o !== 16'sd8) $display("FAIL clr_b_hold: b_o=%0d want 8", b_o); else pass++;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            seen |= ps_valid_o | busy_o;
        end
        total++; if (seen !== 1'b0) $display("FAIL clr_drop: pv/busy seen=%b want 0", seen); else pass++;
        drain = 1'b1; tick(1);
        drain = 1'b0;
        total++; if (ps_o !== 32'sd0 || ps_valid_o !== 1'b1) $display("FAIL clr_acc: ps_o=%0d pv=%b want 0 1", ps_o, ps_valid_o); else pass++;
        feed(16'sd1);
        tick(6);
        drain = 1'b1; tick(1);
        drain = 1'b0;
        total++; if (ps_o !== 32'sd8) $display("FAIL clr_active_b: ps_o=%0d want 8", ps_o); else pass++;
        tick(2);
    endtask

    initial begin
        rst = 1'b1; data_clear = 1'b0; mode = 1'b0; b_load = 1'b0; b_swap = 1'b0;
        b_in = '0; a_valid = 1'b0; a_in = '0; ps_valid = 1'b0; ps_in = '0; drain = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        test_reset;
        test_ws;
        test_os;
        test_sat;
        test_bswap;
        test_clear;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
